// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB digit first.
// Carry is registered between digits; sum/cout/ovf update only on completion.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             carry_d;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;
    logic             ovf_q;
    logic [DIGIT-1:0] dig_sum;
    logic             msb_cin;

    // Operands shift right each step, so the live digit is always the low slice.
    always_comb begin
        {carry_d, dig_sum} = {1'b0, a_q[DIGIT-1:0]}
                           + {1'b0, b_q[DIGIT-1:0]}
                           + (DIGIT + 1)'(carry_q);
        msb_cin = dig_sum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
        sh_d    = (sh_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b ^ {WIDTH{sub}};
                        carry_q <= cin ^ sub;
                        cnt_q   <= '0;
                        sh_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    carry_q <= carry_d;
                    sh_q    <= sh_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        sum_q   <= sh_d;
                        cout_q  <= carry_d;
                        ovf_q   <= carry_d ^ msb_cin;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: directed W8 cases plus randomised W16
// operations over every legal DIGIT, checked against an arithmetic model.
module tb_digit_serial_adder;

    localparam int N = 7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_s [N];
    logic        sub_s   [N];
    logic        cin_s   [N];
    logic [15:0] a_s     [N];
    logic [15:0] b_s     [N];
    wire         busy_w  [N];
    wire         done_w  [N];
    wire         cout_w  [N];
    wire         ovf_w   [N];
    wire  [15:0] sum_w   [N];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Instances 0,1: WIDTH=8 with DIGIT 1,4. Instances 2..6: WIDTH=16, DIGIT 1..16.
    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int W = (g < 2) ? 8 : 16;
        localparam int D = (g == 0) ? 1 : (g == 1) ? 4 : (1 << (g - 2));
        logic [W-1:0] s;
        digit_serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .start(start_s[g]),
            .sub  (sub_s[g]),
            .a    (a_s[g][W-1:0]),
            .b    (b_s[g][W-1:0]),
            .cin  (cin_s[g]),
            .busy (busy_w[g]),
            .done (done_w[g]),
            .sum  (s),
            .cout (cout_w[g]),
            .ovf  (ovf_w[g])
        );
        assign sum_w[g] = 16'(s);
    end

    function automatic int w_of(int i);
        return (i < 2) ? 8 : 16;
    endfunction

    function automatic int steps_of(int i);
        int d;
        d = (i == 0) ? 1 : (i == 1) ? 4 : (1 << (i - 2));
        return w_of(i) / d;
    endfunction

    // Returns {ovf, cout, sum[15:0]} from plain integer arithmetic.
    function automatic logic [17:0] model(int w, logic [15:0] aa,
                                          logic [15:0] bb, logic s,
                                          logic c);
        longint unsigned mask, ea, eb, t, r;
        logic sa, sb, sr, co, ov;
        mask = (64'd1 << w) - 1;
        ea   = 64'(aa) & mask;
        eb   = (s ? ~64'(bb) : 64'(bb)) & mask;
        t    = ea + eb + 64'(c ^ s);
        r    = t & mask;
        co   = t[w];
        sa   = ea[w-1];
        sb   = eb[w-1];
        sr   = r[w-1];
        ov   = (sa == sb) && (sr != sa);
        return {ov, co, r[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int i, input logic [15:0] aa,
                          input logic [15:0] bb, input logic s,
                          input logic c);
        a_s[i]     = aa;
        b_s[i]     = bb;
        sub_s[i]   = s;
        cin_s[i]   = c;
        start_s[i] = 1'b1;
        tick();
        start_s[i] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            start_s[i] = 1'b0;
            sub_s[i]   = 1'b0;
            cin_s[i]   = 1'b0;
            a_s[i]     = '0;
            b_s[i]     = '0;
        end
        #12;
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if ({busy_w[i], done_w[i], sum_w[i], cout_w[i], ovf_w[i]}
                !== 19'd0) begin
                n_bad++;
                $display("FAIL reset_outputs inst=%0d got=%b/%b/%h/%b/%b want=0",
                         i, busy_w[i], done_w[i], sum_w[i], cout_w[i],
                         ovf_w[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add_w8();
        logic [17:0] exp;
        exp = model(8, 16'h5A, 16'h33, 1'b0, 1'b0);
        launch(0, 16'h5A, 16'h33, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if ({busy_w[0], done_w[0]} !== 2'b10) begin
                n_bad++;
                $display("FAIL add8_busy k=%0d busy/done=%b%b want=10",
                         k, busy_w[0], done_w[0]);
            end
            tick();
        end
        n_cmp++;
        if ({busy_w[0], done_w[0], ovf_w[0], cout_w[0], sum_w[0]}
            !== {2'b01, exp}) begin
            n_bad++;
            $display("FAIL add8_result got b%b d%b v%b c%b s%h want v%b c%b s%h",
                     busy_w[0], done_w[0], ovf_w[0], cout_w[0], sum_w[0],
                     exp[17], exp[16], exp[15:0]);
        end
        n_cmp++;
        if (sum_w[0] !== 16'h008D || ovf_w[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL add8_const got s%h v%b want s008d v1",
                     sum_w[0], ovf_w[0]);
        end
        tick();
        n_cmp++;
        if (done_w[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL add8_done_pulse got=%b want=0", done_w[0]);
        end
    endtask

    task automatic test_sub_d4();
        logic [17:0] exp;
        logic [15:0] want_s;
        for (int c = 0; c < 2; c++) begin
            exp    = model(8, 16'h10, 16'h20, 1'b1, 1'(c));
            want_s = (c == 0) ? 16'h00F0 : 16'h00EF;
            launch(1, 16'h10, 16'h20, 1'b1, 1'(c));
            tick();
            n_cmp++;
            if ({busy_w[1], done_w[1]} !== 2'b10) begin
                n_bad++;
                $display("FAIL sub4_busy cin=%0d busy/done=%b%b want=10",
                         c, busy_w[1], done_w[1]);
            end
            tick();
            n_cmp++;
            if ({busy_w[1], done_w[1], ovf_w[1], cout_w[1], sum_w[1]}
                !== {2'b01, exp} || sum_w[1] !== want_s) begin
                n_bad++;
                $display("FAIL sub4_result cin=%0d got d%b v%b c%b s%h want v%b c%b s%h",
                         c, done_w[1], ovf_w[1], cout_w[1], sum_w[1],
                         exp[17], exp[16], want_s);
            end
            tick();
        end
    endtask

    // Start held high: each op is accepted at the edge closing its predecessor's
    // done cycle, so dones recur every STEPS+1 edges.
    task automatic test_back_to_back();
        logic [17:0] exp;
        int          ndone;
        exp        = model(8, 16'hFF, 16'h01, 1'b0, 1'b1);
        a_s[0]     = 16'hFF;
        b_s[0]     = 16'h01;
        sub_s[0]   = 1'b0;
        cin_s[0]   = 1'b1;
        start_s[0] = 1'b1;
        ndone      = 0;
        for (int t = 1; t <= 27; t++) begin
            tick();
            if (t == 27) start_s[0] = 1'b0;
            n_cmp++;
            if (done_w[0] !== (((t - 9) % 9 == 0) && t >= 9)) begin
                n_bad++;
                $display("FAIL b2b_done_timing t=%0d got=%b", t, done_w[0]);
            end
            if (done_w[0] === 1'b1) begin
                ndone++;
                n_cmp++;
                if ({busy_w[0], ovf_w[0], cout_w[0], sum_w[0]}
                    !== {1'b0, exp}) begin
                    n_bad++;
                    $display("FAIL b2b_result t=%0d got b%b v%b c%b s%h want v%b c%b s%h",
                             t, busy_w[0], ovf_w[0], cout_w[0], sum_w[0],
                             exp[17], exp[16], exp[15:0]);
                end
            end
        end
        n_cmp++;
        if (ndone != 3) begin
            n_bad++;
            $display("FAIL b2b_count got=%0d want=3", ndone);
        end
        tick();
        n_cmp++;
        if ({busy_w[0], done_w[0]} !== 2'b00) begin
            n_bad++;
            $display("FAIL b2b_stop busy/done=%b%b want=00",
                     busy_w[0], done_w[0]);
        end
    endtask

    task automatic test_ignore_start();
        logic [17:0] exp;
        int          lat;
        exp = model(8, 16'h12, 16'h34, 1'b0, 1'b0);
        launch(0, 16'h12, 16'h34, 1'b0, 1'b0);
        tick();
        tick();
        a_s[0]     = 16'hAA;
        b_s[0]     = 16'h55;
        sub_s[0]   = 1'b1;
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        lat        = 3;
        while (done_w[0] !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        n_cmp++;
        if (lat != 8) begin
            n_bad++;
            $display("FAIL ignore_latency got=%0d want=8", lat);
        end
        n_cmp++;
        if ({ovf_w[0], cout_w[0], sum_w[0]} !== exp) begin
            n_bad++;
            $display("FAIL ignore_result got v%b c%b s%h want v%b c%b s%h",
                     ovf_w[0], cout_w[0], sum_w[0], exp[17], exp[16],
                     exp[15:0]);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        logic [17:0] exp;
        int          lat;
        launch(0, 16'h70, 16'h20, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy_w[0], done_w[0], sum_w[0], cout_w[0], ovf_w[0]}
            !== 19'd0) begin
            n_bad++;
            $display("FAIL midreset_async got b%b d%b s%h c%b v%b want 0",
                     busy_w[0], done_w[0], sum_w[0], cout_w[0], ovf_w[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_cmp++;
            if ({busy_w[0], done_w[0]} !== 2'b00) begin
                n_bad++;
                $display("FAIL midreset_no_done k=%0d busy/done=%b%b",
                         k, busy_w[0], done_w[0]);
            end
        end
        exp = model(8, 16'hC3, 16'h7E, 1'b1, 1'b0);
        launch(0, 16'hC3, 16'h7E, 1'b1, 1'b0);
        lat = 0;
        while (done_w[0] !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        n_cmp++;
        if (lat != 8 || {ovf_w[0], cout_w[0], sum_w[0]} !== exp) begin
            n_bad++;
            $display("FAIL midreset_recover lat=%0d got v%b c%b s%h want lat=8 v%b c%b s%h",
                     lat, ovf_w[0], cout_w[0], sum_w[0], exp[17], exp[16],
                     exp[15:0]);
        end
        tick();
    endtask

    // Each new op launches in the previous op's done cycle.
    task automatic test_random(input int i, input int nops);
        logic [17:0] exp;
        logic [15:0] prev, ra, rb;
        logic        rs, rc;
        int          lat, st;
        st   = steps_of(i);
        prev = sum_w[i];
        for (int op = 0; op < nops; op++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rs  = 1'($urandom);
            rc  = 1'($urandom);
            exp = model(w_of(i), ra, rb, rs, rc);
            launch(i, ra, rb, rs, rc);
            lat = 0;
            while (done_w[i] !== 1'b1 && lat <= st + 2) begin
                n_cmp++;
                if (busy_w[i] !== 1'b1 || sum_w[i] !== prev) begin
                    n_bad++;
                    $display("FAIL rand_hold inst=%0d op=%0d busy=%b sum=%h want busy=1 sum=%h",
                             i, op, busy_w[i], sum_w[i], prev);
                end
                tick();
                lat++;
            end
            n_cmp++;
            if (lat != st) begin
                n_bad++;
                $display("FAIL rand_latency inst=%0d op=%0d got=%0d want=%0d",
                         i, op, lat, st);
                return;
            end
            n_cmp++;
            if ({busy_w[i], ovf_w[i], cout_w[i], sum_w[i]} !== {1'b0, exp}) begin
                n_bad++;
                $display("FAIL rand_result inst=%0d op=%0d a=%h b=%h sub=%b cin=%b got v%b c%b s%h want v%b c%b s%h",
                         i, op, ra, rb, rs, rc, ovf_w[i], cout_w[i],
                         sum_w[i], exp[17], exp[16], exp[15:0]);
            end
            prev = exp[15:0];
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_add_w8();
        test_sub_d4();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid_run();
        for (int i = 2; i < N; i++) test_random(i, 1000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
